// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR over N bits with log2(N) levels split
// across STAGES registered stages, valid/ready on both sides, carry-out and zero flag.
module pipelined_shifter #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 1,
  localparam int unsigned L     = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] IN,
  input  logic [L-1:0] shamt,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] OUT,
  output logic         carry,
  output logic         zero
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Stage that owns shift level k (levels are spread evenly, LSB level first).
  function automatic int unsigned level_stage(input int unsigned k);
    return (k * STAGES) / L;
  endfunction

  // Apply one level: shift/rotate by 2^k according to op.
  function automatic logic [N-1:0] shift_level(input logic [N-1:0] d,
                                               input logic [2:0]   o,
                                               input int unsigned  k);
    int unsigned s;
    logic [N-1:0] r;
    s = 32'd1 << k;
    case (o)
      OP_SLL:  r = d << s;
      OP_SRL:  r = d >> s;
      OP_SRA:  r = N'($signed(d) >>> s);
      OP_ROL:  r = (d << s) | (d >> (N - s));
      OP_ROR:  r = (d >> s) | (d << (N - s));
      default: r = d;
    endcase
    return r;
  endfunction

  logic [STAGES-1:0]           valid_q, valid_d;
  logic [STAGES-1:0][N-1:0]    data_q, data_d;
  logic [STAGES-1:0][2:0]      op_q, op_d;
  logic [STAGES-1:0][L-1:0]    shamt_q, shamt_d;
  logic [STAGES-1:0]           carry_q, carry_d;
  logic                        zero_q, zero_d;

  logic [STAGES-1:0]           ready_c;
  logic [STAGES-1:0]           src_valid_c;
  logic [STAGES-1:0][N-1:0]    src_data_c;
  logic [STAGES-1:0][2:0]      src_op_c;
  logic [STAGES-1:0][L-1:0]    src_shamt_c;
  logic [STAGES-1:0]           src_carry_c;
  logic [L-1:0]                neg_shamt_c;
  logic [L-1:0]                shamt_m1_c;
  logic                        in_carry_c;
  logic [N-1:0]                lvl_data_c;
  logic                        ready_chain_c;
  logic                        unused_c;

  // Bubble-collapsing ready chain: a stage can load if it is empty or its successor moves.
  always_comb begin
    ready_c       = '0;
    ready_chain_c = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      ready_chain_c = !valid_q[i] || ready_chain_c;
      ready_c[i]    = ready_chain_c;
    end
  end

  // Carry is taken straight from the original operand, so no per-level tracking is needed.
  always_comb begin
    neg_shamt_c = ~shamt + L'(1);
    shamt_m1_c  = shamt - L'(1);
    in_carry_c  = 1'b0;
    if (shamt != '0) begin
      case (op)
        OP_SLL, OP_ROL:         in_carry_c = IN[neg_shamt_c];
        OP_SRL, OP_SRA, OP_ROR: in_carry_c = IN[shamt_m1_c];
        default:                in_carry_c = 1'b0;
      endcase
    end
  end

  always_comb begin
    src_valid_c    = '0;
    src_data_c     = '0;
    src_op_c       = '0;
    src_shamt_c    = '0;
    src_carry_c    = '0;
    src_valid_c[0] = in_valid;
    src_data_c[0]  = IN;
    src_op_c[0]    = op;
    src_shamt_c[0] = shamt;
    src_carry_c[0] = in_carry_c;
    for (int unsigned i = 1; i < STAGES; i++) begin
      src_valid_c[i] = valid_q[i-1];
      src_data_c[i]  = data_q[i-1];
      src_op_c[i]    = op_q[i-1];
      src_shamt_c[i] = shamt_q[i-1];
      src_carry_c[i] = carry_q[i-1];
    end
  end

  // Next state: a ready stage takes the upstream valid; payload only moves with a valid request.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    op_d       = op_q;
    shamt_d    = shamt_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    lvl_data_c = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (ready_c[i]) begin
        valid_d[i] = src_valid_c[i];
        if (src_valid_c[i]) begin
          lvl_data_c = src_data_c[i];
          for (int unsigned k = 0; k < L; k++) begin
            if (level_stage(k) == i && src_shamt_c[i][k]) begin
              lvl_data_c = shift_level(lvl_data_c, src_op_c[i], k);
            end
          end
          data_d[i]  = lvl_data_c;
          op_d[i]    = src_op_c[i];
          shamt_d[i] = src_shamt_c[i];
          carry_d[i] = src_carry_c[i];
        end
      end
    end
    if (ready_c[STAGES-1] && src_valid_c[STAGES-1]) begin
      zero_d = (data_d[STAGES-1] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      op_q    <= '0;
      shamt_q <= '0;
      carry_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = ready_c[0];
  assign out_valid = valid_q[STAGES-1];
  assign OUT       = data_q[STAGES-1];
  assign carry     = carry_q[STAGES-1];
  assign zero      = zero_q;

  // The last stage's op/shamt copies have no consumer.
  assign unused_c = ^{op_q[STAGES-1], shamt_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed vectors, latency/backpressure/reset sequences,
// and a random valid/ready run on every (N, STAGES) combination for N = 8, 16, 32.
module tb_pipelined_shifter;

  localparam int NCFG  = 12;
  localparam int G32S1 = 7;
  localparam int G32S5 = 11;
  localparam int NTX   = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NCFG-1:0]       iv, ordy, ir, ov, cy, zr;
  logic [NCFG-1:0][31:0] din, dout;
  logic [NCFG-1:0][4:0]  sh;
  logic [NCFG-1:0][2:0]  opv;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int unsigned GN = (g < 3) ? 8 : (g < 7) ? 16 : 32;
    localparam int unsigned GS = (g < 3) ? g + 1 : (g < 7) ? g - 2 : g - 6;
    localparam int unsigned GL = $clog2(GN);
    logic [GN-1:0] o;
    pipelined_shifter #(.N(GN), .STAGES(GS)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .IN        (din[g][GN-1:0]),
      .shamt     (sh[g][GL-1:0]),
      .op        (opv[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .OUT       (o),
      .carry     (cy[g]),
      .zero      (zr[g])
    );
    assign dout[g] = 32'(o);
  end

  function automatic int cfg_n(input int g);
    return (g < 3) ? 8 : (g < 7) ? 16 : 32;
  endfunction

  function automatic int cfg_s(input int g);
    return (g < 3) ? g + 1 : (g < 7) ? g - 2 : g - 6;
  endfunction

  // Bit-by-bit reference: returns {carry, result}.
  function automatic logic [32:0] model(input int n, input logic [31:0] x,
                                        input int s, input logic [2:0] o);
    logic [31:0] r;
    logic c;
    r = '0;
    c = 1'b0;
    for (int j = 0; j < n; j++) begin
      case (o)
        3'd0:    if (j >= s) r[j] = x[j-s];
        3'd1:    if (j + s < n) r[j] = x[j+s];
        3'd2:    r[j] = (j + s < n) ? x[j+s] : x[n-1];
        3'd3:    r[j] = x[(j + n - s) % n];
        3'd4:    r[j] = x[(j + s) % n];
        default: r[j] = x[j];
      endcase
    end
    if (s != 0) begin
      case (o)
        3'd0, 3'd3:       c = x[n-s];
        3'd1, 3'd2, 3'd4: c = x[s-1];
        default:          c = 1'b0;
      endcase
    end
    return {c, r};
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int g = 0; g < NCFG; g++) begin
      iv[g]   = 1'b0;
      ordy[g] = 1'b1;
      din[g]  = '0;
      sh[g]   = '0;
      opv[g]  = '0;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] in;
    logic [4:0]  sh;
    logic [31:0] out;
    logic        c;
    logic        z;
  } vec_t;

  vec_t vecs[14];

  logic [32:0] sb   [NCFG][NTX];
  int          hd   [NCFG];
  int          tl   [NCFG];
  int          occ  [NCFG];
  logic        pop  [NCFG];
  logic        stall[NCFG];
  logic [31:0] h_d  [NCFG];
  logic        h_c  [NCFG];
  logic        h_z  [NCFG];

  initial begin
    logic [32:0] e;
    logic [32:0] bp_exp [10];
    logic [31:0] lat_in [8];
    int          bp_hd, bp_sent, bp_occ, n, s;
    logic        bp_stall, done;
    logic [31:0] bh_d;
    logic        bh_c, bh_z;

    vecs[0]  = '{3'b010, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0};
    vecs[2]  = '{3'b000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1, 1'b0};
    vecs[3]  = '{3'b001, 32'h0000_0001, 5'd1,  32'h0000_0000, 1'b1, 1'b1};
    vecs[4]  = '{3'b011, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b1, 1'b0};
    vecs[5]  = '{3'b100, 32'h8000_0001, 5'd4,  32'h1800_0000, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[8]  = '{3'b000, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0};
    vecs[9]  = '{3'b010, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{3'b011, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0, 1'b0};
    vecs[11] = '{3'b101, 32'h0000_0000, 5'd3,  32'h0000_0000, 1'b0, 1'b1};
    vecs[12] = '{3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[13] = '{3'b100, 32'h0000_0001, 5'd31, 32'h0000_0002, 1'b0, 1'b0};

    // Reset held two cycles with requests offered everywhere.
    reset = 1'b1;
    idle_all();
    for (int g = 0; g < NCFG; g++) begin
      iv[g]  = 1'b1;
      din[g] = 32'hFFFF_FFFF;
      sh[g]  = 5'd1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_all();
    #1;
    for (int g = G32S1; g < NCFG; g += G32S5 - G32S1) begin
      chk($sformatf("rst_out_valid[%0d]", g), 32'(ov[g]), 32'd0);
      chk($sformatf("rst_out[%0d]", g), dout[g], 32'd0);
      chk($sformatf("rst_carry[%0d]", g), 32'(cy[g]), 32'd0);
      chk($sformatf("rst_zero[%0d]", g), 32'(zr[g]), 32'd0);
      chk($sformatf("rst_in_ready[%0d]", g), 32'(ir[g]), 32'd1);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) chk($sformatf("rst_no_result[%0d]", g), 32'(ov[g]), 32'd0);
    end

    // Directed vectors on N=32, STAGES=1, back to back.
    for (int i = 0; i < 14; i++) begin
      iv[G32S1]  = 1'b1;
      din[G32S1] = vecs[i].in;
      sh[G32S1]  = vecs[i].sh;
      opv[G32S1] = vecs[i].op;
      #1 chk($sformatf("vec%0d_in_ready", i), 32'(ir[G32S1]), 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(ov[G32S1]), 32'd1);
      chk($sformatf("vec%0d_out", i), dout[G32S1], vecs[i].out);
      chk($sformatf("vec%0d_carry", i), 32'(cy[G32S1]), 32'(vecs[i].c));
      chk($sformatf("vec%0d_zero", i), 32'(zr[G32S1]), 32'(vecs[i].z));
    end
    iv[G32S1] = 1'b0;
    @(negedge clk);
    chk("vec_drain", 32'(ov[G32S1]), 32'd0);

    // Latency and throughput on STAGES=5: 8 back-to-back requests.
    for (int j = 0; j < 8; j++) lat_in[j] = 32'h8F0F_1235 + 32'(j) * 32'h1111_1111;
    for (int k = 0; k < 14; k++) begin
      if (k >= 1) begin
        @(negedge clk);
        chk($sformatf("lat_valid_c%0d", k), 32'(ov[G32S5]), 32'((k >= 5) && (k <= 12)));
        if (ov[G32S5] && k >= 5 && k <= 12) begin
          e = model(32, lat_in[k-5], (k - 5) * 4 + 1, 3'(k - 5));
          chk($sformatf("lat_out%0d", k - 5), dout[G32S5], e[31:0]);
          chk($sformatf("lat_carry%0d", k - 5), 32'(cy[G32S5]), 32'(e[32]));
        end
      end
      if (k < 8) begin
        iv[G32S5]  = 1'b1;
        din[G32S5] = lat_in[k];
        sh[G32S5]  = 5'(k * 4 + 1);
        opv[G32S5] = 3'(k);
        #1 chk($sformatf("lat_in_ready%0d", k), 32'(ir[G32S5]), 32'd1);
      end else begin
        iv[G32S5] = 1'b0;
      end
    end

    // Backpressure on STAGES=5: 10 requests, out_ready low for three cycles mid-stream.
    for (int j = 0; j < 10; j++) bp_exp[j] = model(32, 32'hA5C3_0F01 + 32'(j) * 32'h0101_0103, (j * 3) % 32, 3'(j % 5));
    bp_hd = 0; bp_sent = 0; bp_occ = 0; bp_stall = 1'b0;
    bh_d = '0; bh_c = 1'b0; bh_z = 1'b0;
    for (int c = 0; c < 60 && bp_hd < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (bp_stall) begin
        chk("bp_hold_valid", 32'(ov[G32S5]), 32'd1);
        chk("bp_hold_out", dout[G32S5], bh_d);
        chk("bp_hold_carry", 32'(cy[G32S5]), 32'(bh_c));
        chk("bp_hold_zero", 32'(zr[G32S5]), 32'(bh_z));
      end
      ordy[G32S5] = !(c >= 8 && c <= 10);
      pop[0] = ov[G32S5] && ordy[G32S5];
      if (pop[0]) begin
        chk($sformatf("bp_out%0d", bp_hd), dout[G32S5], bp_exp[bp_hd][31:0]);
        chk($sformatf("bp_carry%0d", bp_hd), 32'(cy[G32S5]), 32'(bp_exp[bp_hd][32]));
        chk($sformatf("bp_zero%0d", bp_hd), 32'(zr[G32S5]), 32'(bp_exp[bp_hd][31:0] == 32'd0));
        bp_hd++;
      end
      bp_stall = ov[G32S5] && !ordy[G32S5];
      bh_d = dout[G32S5]; bh_c = cy[G32S5]; bh_z = zr[G32S5];
      iv[G32S5]  = (bp_sent < 10);
      din[G32S5] = 32'hA5C3_0F01 + 32'(bp_sent) * 32'h0101_0103;
      sh[G32S5]  = 5'((bp_sent * 3) % 32);
      opv[G32S5] = 3'(bp_sent % 5);
      #1;
      chk($sformatf("bp_in_ready_c%0d", c), 32'(ir[G32S5]), 32'((bp_occ < 5) || ordy[G32S5]));
      if (c == 8) chk("bp_full_in_ready", 32'(ir[G32S5]), 32'd0);
      if (iv[G32S5] && ir[G32S5]) begin
        bp_sent++;
        bp_occ++;
      end
      if (pop[0]) bp_occ--;
    end
    chk("bp_all_received", 32'(bp_hd), 32'd10);
    idle_all();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("bp_no_duplicate", 32'(ov[G32S5]), 32'd0);
    end

    // Reset while three requests are in flight: none of them may emerge.
    for (int j = 0; j < 3; j++) begin
      iv[G32S5]  = 1'b1;
      din[G32S5] = 32'h0000_00F0 << j;
      sh[G32S5]  = 5'd2;
      opv[G32S5] = 3'b000;
      @(negedge clk);
    end
    reset = 1'b1;
    iv[G32S5] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_out", dout[G32S5], 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(ov[G32S5]), 32'd0);
    end

    // Random valid/ready on every configuration against the reference model.
    for (int g = 0; g < NCFG; g++) begin
      hd[g] = 0; tl[g] = 0; occ[g] = 0; stall[g] = 1'b0; pop[g] = 1'b0;
      h_d[g] = '0; h_c[g] = 1'b0; h_z[g] = 1'b0;
    end
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) begin
        n = cfg_n(g);
        if (stall[g]) begin
          chk($sformatf("rnd_hold_valid[%0d]", g), 32'(ov[g]), 32'd1);
          chk($sformatf("rnd_hold_out[%0d]", g), dout[g], h_d[g]);
          chk($sformatf("rnd_hold_carry[%0d]", g), 32'(cy[g]), 32'(h_c[g]));
          chk($sformatf("rnd_hold_zero[%0d]", g), 32'(zr[g]), 32'(h_z[g]));
        end
        ordy[g] = ($urandom_range(0, 3) != 0);
        pop[g]  = ov[g] && ordy[g];
        if (pop[g]) begin
          if (hd[g] >= tl[g]) begin
            chk($sformatf("rnd_spurious[%0d]", g), 32'(ov[g]), 32'd0);
          end else begin
            e = sb[g][hd[g]];
            chk($sformatf("rnd_out[%0d]#%0d", g, hd[g]), dout[g], e[31:0]);
            chk($sformatf("rnd_carry[%0d]#%0d", g, hd[g]), 32'(cy[g]), 32'(e[32]));
            chk($sformatf("rnd_zero[%0d]#%0d", g, hd[g]), 32'(zr[g]), 32'(e[31:0] == 32'd0));
            hd[g]++;
          end
        end
        stall[g] = ov[g] && !ordy[g];
        h_d[g] = dout[g]; h_c[g] = cy[g]; h_z[g] = zr[g];
        iv[g]  = (tl[g] < NTX) && ($urandom_range(0, 3) != 0);
        din[g] = $urandom;
        sh[g]  = 5'($urandom_range(0, n - 1));
        opv[g] = 3'($urandom_range(0, 7));
      end
      #1;
      done = 1'b1;
      for (int g = 0; g < NCFG; g++) begin
        n = cfg_n(g);
        s = cfg_s(g);
        chk($sformatf("rnd_in_ready[%0d]", g), 32'(ir[g]), 32'((occ[g] < s) || ordy[g]));
        if (iv[g] && ir[g]) begin
          sb[g][tl[g]] = model(n, din[g], int'(sh[g]), opv[g]);
          tl[g]++;
          occ[g]++;
        end
        if (pop[g]) occ[g]--;
        if (tl[g] < NTX || hd[g] < tl[g]) done = 1'b0;
      end
    end
    chk("rnd_completed", 32'(done), 32'd1);
    idle_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
